// File: rtl/sccb_config_seq.sv
// Camera register-initialisation sequencer: walks a {sub_addr, value} ROM table and
// issues SCCB writes (with optional read-back verify) through a start/done handshake.
module sccb_config_seq #(
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter bit          VERIFY         = 1'b1,
  parameter logic [23:0] DELAY_CYCLES   = 24'd240000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        XCLK,
  input  logic        RST,
  input  logic        go,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_start,
  output logic [7:0]  sccb_ip_addr,
  output logic [7:0]  sccb_sub_addr,
  output logic [7:0]  sccb_data_in,
  input  logic [7:0]  sccb_data_out,
  input  logic        sccb_done,
  output logic        busy,
  output logic        cfg_done,
  output logic        err,
  output logic        timeout,
  output logic [7:0]  err_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, WR_REL, RD_REQ,
    RD_WAIT, RD_REL, CHECK, DELAY, NEXT, FINISH
  } state_t;

  state_t      state, state_d;
  logic [7:0]  rom_addr_d, ip_d, sub_d, data_d, rd_byte, rd_byte_d, err_count_d;
  logic        start_d, busy_d, cfg_done_d, err_d, timeout_d;
  logic [23:0] cnt, cnt_d;
  logic        cnt_last_to, cnt_last_dly;

  // cnt holds cycles already spent in the current state; compare one ahead so the
  // state lasts exactly the configured number of cycles
  assign cnt_last_to  = ({1'b0, cnt} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};
  assign cnt_last_dly = ({1'b0, cnt} + 25'd1) >= {1'b0, DELAY_CYCLES};

  always_ff @(posedge XCLK) begin
    if (RST) begin
      state         <= IDLE;
      rom_addr      <= '0;
      sccb_start    <= 1'b0;
      sccb_ip_addr  <= DEV_ID;
      sccb_sub_addr <= '0;
      sccb_data_in  <= '0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
      err           <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      rd_byte       <= '0;
      cnt           <= '0;
    end else begin
      state         <= state_d;
      rom_addr      <= rom_addr_d;
      sccb_start    <= start_d;
      sccb_ip_addr  <= ip_d;
      sccb_sub_addr <= sub_d;
      sccb_data_in  <= data_d;
      busy          <= busy_d;
      cfg_done      <= cfg_done_d;
      err           <= err_d;
      timeout       <= timeout_d;
      err_count     <= err_count_d;
      rd_byte       <= rd_byte_d;
      cnt           <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    rom_addr_d  = rom_addr;
    start_d     = sccb_start;
    ip_d        = sccb_ip_addr;
    sub_d       = sccb_sub_addr;
    data_d      = sccb_data_in;
    busy_d      = busy;
    cfg_done_d  = cfg_done;
    err_d       = err;
    timeout_d   = timeout;
    err_count_d = err_count;
    rd_byte_d   = rd_byte;

    unique case (state)
      IDLE: begin
        if (go) begin
          rom_addr_d  = '0;
          cfg_done_d  = 1'b0;
          err_d       = 1'b0;
          timeout_d   = 1'b0;
          err_count_d = '0;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_d = FINISH;
        end else if (rom_data == 16'hFFF0) begin
          state_d = DELAY;
        end else begin
          sub_d   = rom_data[15:8];
          data_d  = rom_data[7:0];
          ip_d    = DEV_ID & 8'hFE;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        start_d = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (sccb_done) begin
          start_d = 1'b0;
          state_d = WR_REL;
        end else if (cnt_last_to) begin
          start_d   = 1'b0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      WR_REL: begin
        if (!sccb_done) begin
          state_d = VERIFY ? RD_REQ : NEXT;
        end else if (cnt_last_to) begin
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      RD_REQ: begin
        ip_d    = DEV_ID | 8'h01;
        start_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (sccb_done) begin
          rd_byte_d = sccb_data_out;
          start_d   = 1'b0;
          state_d   = RD_REL;
        end else if (cnt_last_to) begin
          start_d   = 1'b0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      RD_REL: begin
        if (!sccb_done) begin
          state_d = CHECK;
        end else if (cnt_last_to) begin
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      CHECK: begin
        if (rd_byte != sccb_data_in) begin
          err_d = 1'b1;
          if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
        end
        state_d = NEXT;
      end
      DELAY: begin
        if (cnt_last_dly) state_d = NEXT;
      end
      NEXT: begin
        if (rom_addr == 8'hFF) begin
          state_d = FINISH;
        end else begin
          rom_addr_d = rom_addr + 8'd1;
          state_d    = FETCH;
        end
      end
      FINISH: begin
        busy_d     = 1'b0;
        cfg_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // one shared counter serves the timeout and delay states; any state change restarts it
    cnt_d = (state_d != state) ? '0 : cnt + 24'd1;
  end

endmodule
